// File: rtl/demux8way_16bit_reg.sv
// demux8way_16bit_reg: routes one 16-bit word per handshake into one of
// eight held channels (A..H), each with its own valid flag and consumer ack.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   in, in_valid       producer word and its valid
//   in_ready           target channel is empty (never depends on in_valid)
//   select             target channel when AUTO_SELECT=0 (0=A .. 7=H)
//   outA..outH         channel holding registers
//   out_valid, out_ack per-channel occupied flag / consumer take
//   ptr                round-robin pointer (stays 0 when AUTO_SELECT=0)
//   xfer_count         accepted words, modulo 2^CNT_W
module demux8way_16bit_reg #(
  parameter bit AUTO_SELECT = 1'b0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in,
  input  logic [2:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      outA,
  output logic [15:0]      outB,
  output logic [15:0]      outC,
  output logic [15:0]      outD,
  output logic [15:0]      outE,
  output logic [15:0]      outF,
  output logic [15:0]      outG,
  output logic [15:0]      outH,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ack,
  output logic [2:0]       ptr,
  output logic [CNT_W-1:0] xfer_count
);

  logic [7:0][15:0]  regs;
  logic [7:0]        vld;
  logic [2:0]        ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        tgt;
  logic [7:0]        tgt_oh;
  logic              acc;

  assign tgt      = AUTO_SELECT ? ptr_q : select;
  assign tgt_oh   = 8'b1 << tgt;
  assign in_ready = ~vld[tgt];
  assign acc      = in_valid & in_ready;

  // Data only moves on accept; consumption just drops the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (acc) begin
      regs[tgt] <= in;
    end
  end

  // Ack and accept never hit the same channel: ready is low while valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld <= (vld & ~out_ack) | (acc ? tgt_oh : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (acc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Pointer only advances on accept, so a stall never skips a channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (AUTO_SELECT && acc) begin
      ptr_q <= ptr_q + 3'd1;
    end
  end

  assign outA       = regs[0];
  assign outB       = regs[1];
  assign outC       = regs[2];
  assign outD       = regs[3];
  assign outE       = regs[4];
  assign outF       = regs[5];
  assign outG       = regs[6];
  assign outH       = regs[7];
  assign out_valid  = vld;
  assign ptr        = ptr_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_demux8way_16bit_reg.sv
// tb_demux8way_16bit_reg: addressed and auto-select instances checked
// against a behavioural channel model every cycle, plus directed cases.
module tb_demux8way_16bit_reg;

  logic        clk;
  logic        rst_n;
  logic [15:0] din [2];
  logic [2:0]  sel [2];
  logic        iv  [2];
  logic [7:0]  ack [2];
  wire         rdy [2];
  wire  [15:0] q0  [8];
  wire  [15:0] q1  [8];
  wire  [7:0]  ov  [2];
  wire  [2:0]  ptr [2];
  wire  [7:0]  cnt [2];

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [15:0] mdata  [2][8];
  logic [7:0]  mvalid [2];
  int          mptr   [2];
  int          mcnt   [2];

  demux8way_16bit_reg #(.AUTO_SELECT(1'b0), .CNT_W(8)) u_addr (
    .clk(clk), .rst_n(rst_n), .in(din[0]), .select(sel[0]),
    .in_valid(iv[0]), .in_ready(rdy[0]),
    .outA(q0[0]), .outB(q0[1]), .outC(q0[2]), .outD(q0[3]),
    .outE(q0[4]), .outF(q0[5]), .outG(q0[6]), .outH(q0[7]),
    .out_valid(ov[0]), .out_ack(ack[0]), .ptr(ptr[0]),
    .xfer_count(cnt[0])
  );

  demux8way_16bit_reg #(.AUTO_SELECT(1'b1), .CNT_W(8)) u_auto (
    .clk(clk), .rst_n(rst_n), .in(din[1]), .select(sel[1]),
    .in_valid(iv[1]), .in_ready(rdy[1]),
    .outA(q1[0]), .outB(q1[1]), .outC(q1[2]), .outD(q1[3]),
    .outE(q1[4]), .outF(q1[5]), .outG(q1[6]), .outH(q1[7]),
    .out_valid(ov[1]), .out_ack(ack[1]), .ptr(ptr[1]),
    .xfer_count(cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dq(int i, int c);
    return (i == 0) ? q0[c] : q1[c];
  endfunction

  function automatic int mtgt(int i);
    return (i == 1) ? mptr[i] : int'(sel[i]);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word is taken iff its target channel is empty.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < 8; c++) mdata[i][c] <= 16'h0;
        mvalid[i] <= 8'h00;
        mptr[i]   <= 0;
        mcnt[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int t;
        logic [7:0] nv;
        t  = mtgt(i);
        nv = mvalid[i];
        for (int c = 0; c < 8; c++)
          if (ack[i][c]) nv[c] = 1'b0;
        if (iv[i] && !mvalid[i][t]) begin
          mdata[i][t] <= din[i];
          nv[t] = 1'b1;
          mcnt[i] <= (mcnt[i] + 1) % 256;
          if (i == 1) mptr[i] <= (mptr[i] + 1) % 8;
        end
        mvalid[i] <= nv;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < 8; c++)
          chk($sformatf("data%0d_%0d", i, c), 32'(dq(i, c)),
              32'(mdata[i][c]));
        chk($sformatf("valid%0d", i), 32'(ov[i]), 32'(mvalid[i]));
        chk($sformatf("ptr%0d", i), 32'(ptr[i]), 32'(mptr[i]));
        chk($sformatf("cnt%0d", i), 32'(cnt[i]), 32'(mcnt[i]));
        chk($sformatf("ready%0d", i), 32'(rdy[i]),
            32'(!mvalid[i][mtgt(i)]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      din[i] = 16'h0;
      sel[i] = 3'd0;
      iv[i]  = 1'b0;
      ack[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_valid0", 32'(ov[0]), 32'h0);
    chk("rst_outA1", 32'(q1[0]), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_ptr1", 32'(ptr[1]), 32'h0);
    chk("rst_cnt0", 32'(cnt[0]), 32'h0);

    // addressed write to F
    din[0] = 16'h1234; sel[0] = 3'd5; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    chk("t1_outF", 32'(q0[5]), 32'h1234);
    chk("t1_valid", 32'(ov[0]), 32'h20);
    chk("t1_cnt", 32'(cnt[0]), 32'h1);
    chk("t1_outE", 32'(q0[4]), 32'h0);

    // stall on occupied F, then ack frees it
    din[0] = 16'hBEEF; iv[0] = 1'b1;
    #1;
    chk("t2_ready_lo", 32'(rdy[0]), 32'h0);
    tick();
    chk("t2_hold", 32'(q0[5]), 32'h1234);
    ack[0] = 8'h20;
    tick();
    ack[0] = 8'h00;
    chk("t2_cleared", 32'(ov[0]), 32'h0);
    chk("t2_ready_hi", 32'(rdy[0]), 32'h1);
    chk("t2_retain", 32'(q0[5]), 32'h1234);
    tick();
    iv[0] = 1'b0;
    chk("t2_beef", 32'(q0[5]), 32'hBEEF);
    chk("t2_cnt", 32'(cnt[0]), 32'h2);

    // ack on C while writing G; ack on empty D
    din[0] = 16'h00C2; sel[0] = 3'd2; iv[0] = 1'b1;
    tick();
    din[0] = 16'h00C6; sel[0] = 3'd6; ack[0] = 8'h04;
    tick();
    iv[0] = 1'b0; ack[0] = 8'h08;
    chk("t5_valid", 32'(ov[0]), 32'h60);
    tick();
    ack[0] = 8'h00;
    chk("t5_noop", 32'(ov[0]), 32'h60);
    chk("t5_cnt", 32'(cnt[0]), 32'h4);

    // auto mode, acks held high, nine words
    ack[1] = 8'hFF; iv[1] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      din[1] = 16'(k);
      chk("t3_ptr", 32'(ptr[1]), 32'(k % 8));
      tick();
    end
    iv[1] = 1'b0;
    chk("t3_outA", 32'(q1[0]), 32'h8);
    chk("t3_outH", 32'(q1[7]), 32'h7);
    chk("t3_cnt", 32'(cnt[1]), 32'h9);
    chk("t3_ptr_end", 32'(ptr[1]), 32'h1);
    tick();
    ack[1] = 8'h00;

    // auto mode without acks: fill all eight then stall
    do_reset();
    iv[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      din[1] = 16'h0100 + 16'(k);
      tick();
    end
    chk("t4_full", 32'(ov[1]), 32'hFF);
    chk("t4_ptr", 32'(ptr[1]), 32'h0);
    chk("t4_ready", 32'(rdy[1]), 32'h0);
    chk("t4_cnt", 32'(cnt[1]), 32'h8);
    chk("t4_outA", 32'(q1[0]), 32'h0100);
    ack[1] = 8'h01;
    tick();
    ack[1] = 8'h00;
    din[1] = 16'hA5A5;
    tick();
    chk("t4_refill", 32'(q1[0]), 32'hA5A5);
    chk("t4_ptr1", 32'(ptr[1]), 32'h1);
    chk("t4_cnt9", 32'(cnt[1]), 32'h9);
    tick();
    iv[1] = 1'b0;
    chk("t4_stall", 32'(cnt[1]), 32'h9);

    // mid-cycle asynchronous reset with C..F occupied
    iv[0] = 1'b1;
    for (int k = 2; k < 6; k++) begin
      sel[0] = 3'(k);
      din[0] = 16'h0F00 + 16'(k);
      tick();
    end
    iv[0] = 1'b0;
    chk("t6_pre", 32'(ov[0]), 32'h3C);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(ov[0]), 32'h0);
    chk("t6_outC", 32'(q0[2]), 32'h0);
    chk("t6_cnt", 32'(cnt[0]), 32'h0);
    chk("t6_auto", 32'(ov[1]), 32'h0);
    tick();
    rst_n = 1'b1;

    // counter wrap after 256 accepts
    iv[0] = 1'b1; ack[0] = 8'hFF;
    for (int k = 0; k < 256; k++) begin
      sel[0] = 3'(k % 8);
      din[0] = 16'(k);
      tick();
      if (k == 254) chk("wrap_255", 32'(cnt[0]), 32'hFF);
    end
    iv[0] = 1'b0;
    chk("wrap_0", 32'(cnt[0]), 32'h0);
    tick();
    idle();

    // randomized traffic on both instances
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        din[i] = 16'($urandom);
        sel[i] = 3'($urandom_range(0, 7));
        iv[i]  = ($urandom_range(0, 3) != 0);
        ack[i] = 8'($urandom) & 8'($urandom);
      end
      if (n == 800) begin
        #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/demux8way_16bit_reg.md
Name: demux8way_16bit_reg

Overview:
- Write-side counterpart of the 8-way 16-bit read mux.
- Accepts one 16-bit word per handshake and routes it into one of eight 16-bit holding registers (channels A..H).
- Each channel has its own valid flag and consumer acknowledge.
- Channel selection is either addressed by a 3-bit select, or automatic round-robin via an internal pointer.
- Sits between a single producer and eight consumers, such as register-bank fill or fan-out of a datapath bus.

Parameters:
- AUTO_SELECT, 0: 0 = channel taken from select; 1 = select ignored, internal pointer chooses the channel.
- CNT_W, 8: width of the accepted-word counter xfer_count.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  16  data word from producer.
- select  input  3  target channel (0=A ... 7=H); used only when AUTO_SELECT=0.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block can accept the word this cycle.
- outA..outH  output  16 each  channel holding registers.
- out_valid  output  8  bit i set = channel i holds an unconsumed word.
- out_ack  input  8  bit i = consumer i takes its word.
- ptr  output  3  current round-robin pointer; stays 0 when AUTO_SELECT=0.
- xfer_count  output  CNT_W  number of accepted words, modulo 2^CNT_W.

Behaviour:
Target channel and ready:
- Target channel t = AUTO_SELECT ? ptr : select (combinational).
- in_ready = ~out_valid[t], combinational from current state and select. It is never a function of in_valid.

Accept:
- Accept occurs at a rising edge with in_valid && in_ready.
- On accept: out<t> <= in; out_valid[t] <= 1; xfer_count <= xfer_count+1, wrapping from 2^CNT_W-1 to 0.
- On accept with AUTO_SELECT=1: ptr <= ptr+1, wrapping 7 -> 0.

Latency:
- Data and valid appear on the channel outputs one cycle after the accepting edge.

Consume:
- At an edge with out_ack[i] && out_valid[i], out_valid[i] <= 0.
- out<i> retains its data after consumption; data registers change only on accept.
- out_ack[i] while out_valid[i]=0 has no effect.

Simultaneous events:
- Ack and new write to the same channel in the same cycle cannot occur: ready is 0 while that channel is valid. There is no bypass, so the same channel is reused at most every 2 cycles.
- Ack on channel i and accept on channel j≠i in the same cycle are both performed.
- Multiple acks in one cycle are all performed.

Stall:
- In AUTO mode, a stall on an occupied channel holds ptr. Channels are never skipped, so strict rotation order is preserved.
- In addressed mode, a producer may change select while stalled; in_ready follows the new select in the same cycle.

Reset:
- rst_n low asynchronously forces outA..outH=0, out_valid=0, ptr=0, xfer_count=0, regardless of clk.
- Reset mid-transfer discards all held words.
- The first accept occurs no earlier than the first rising edge after rst_n rises.

Other rules:
- No X propagation: select is fully decoded, all 8 codes valid.

Test Plan:
1. Addressed mode, reset, then in=16'h1234, select=5, in_valid=1 for one cycle -> next cycle outF=16'h1234, out_valid=8'b0010_0000, xfer_count=1, other outputs 0.
2. Channel 5 still valid, select=5, in=16'hBEEF, in_valid=1 -> in_ready=0, outF stays 16'h1234. Assert out_ack[5] -> valid clears next edge, in_ready rises, BEEF is accepted on the following edge.
3. AUTO_SELECT=1, present 9 consecutive words 16'h0000..16'h0008 with all acks held high -> words land A,B,...,H then A (A=16'h0008), ptr sequence 0..7,0,1, xfer_count=9.
4. AUTO_SELECT=1, no acks, 10 words offered -> 8 accepted, in_ready=0 with ptr=0 and out_valid=8'hFF. Ack channel A only -> exactly one more word accepted into A, ptr=1, then stall again.
5. Same-cycle events: ack channel 2 while writing channel 6 -> out_valid[2]=0 and out_valid[6]=1 after the edge. Ack on an empty channel 3 -> no state change.
6. Mid-stream reset: assert rst_n=0 between clock edges with out_valid=8'h3C -> outputs go to 0 immediately without a clock edge. With CNT_W=8, 256 accepts -> xfer_count wraps to 0.
